// File: rtl/rr_grant_sequencer_if.sv
// Request/grant bundle between the requesters and the round-robin grant sequencer.
// Requesters drive i_req/i_done; the sequencer drives the registered grant outputs.
interface rr_grant_sequencer_if #(
    parameter int N = 4
);
    localparam int IW = $clog2(N);

    logic [N-1:0]  i_req;
    logic          i_done;
    logic [N-1:0]  o_grant;
    logic [IW-1:0] o_grant_idx;
    logic          o_grant_valid;
    logic          o_timeout;

    modport master (
        output i_req,
        output i_done,
        input  o_grant,
        input  o_grant_idx,
        input  o_grant_valid,
        input  o_timeout
    );

    modport slave (
        input  i_req,
        input  i_done,
        output o_grant,
        output o_grant_idx,
        output o_grant_valid,
        output o_timeout
    );
endinterface

// File: rtl/rr_grant_sequencer.sv
// Round-robin grant stage: rotates requests by the last grantee, priority-encodes,
// holds a one-hot grant until done, request drop, or the MAX_HOLD limit.
module rr_grant_sequencer #(
    parameter int N        = 4,
    parameter int MAX_HOLD = 8
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    rr_grant_sequencer_if.slave     bus
);
    localparam int  IW      = $clog2(N);
    localparam int  CW      = (MAX_HOLD < 2) ? 2 : $clog2(MAX_HOLD + 1);
    localparam bit  LIMITED = (MAX_HOLD != 0);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    // Handshake: a requester raises i_req[i] and keeps it high while it wants the
    // resource; once o_grant[i] is seen it owns the resource until it pulses
    // i_done or drops i_req[i], or the hold limit takes the grant away.
    state_t        state_q, state_d;
    logic [IW-1:0] ptr_q, ptr_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          valid_q, valid_d;
    logic [N-1:0]  grant_q, grant_d;
    logic [CW-1:0] hold_q, hold_d;
    logic          timeout_q, timeout_d;

    logic [IW:0]   sel;
    logic [IW:0]   resel;
    logic          rel_done, rel_drop, rel_to;

    // Search ptr+1, ptr+2, ... ending at ptr; returns {found, index}.
    function automatic logic [IW:0] pick(input logic [N-1:0] req, input logic [IW-1:0] ptr);
        logic          found;
        logic [IW-1:0] win;
        int            idx;
        found = 1'b0;
        win   = '0;
        for (int k = 1; k <= N; k++) begin
            idx = (int'(ptr) + k) % N;
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = idx[IW-1:0];
            end
        end
        return {found, win};
    endfunction

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        idx_d     = idx_q;
        valid_d   = valid_q;
        hold_d    = hold_q;
        timeout_d = 1'b0;
        sel       = pick(bus.i_req, ptr_q);
        resel     = pick(bus.i_req, idx_q);
        rel_done  = 1'b0;
        rel_drop  = 1'b0;
        rel_to    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (sel[IW]) begin
                    state_d = ST_GRANT;
                    idx_d   = sel[IW-1:0];
                    valid_d = 1'b1;
                    hold_d  = CW'(1);
                end
            end
            ST_GRANT: begin
                rel_done = bus.i_done;
                rel_drop = !bus.i_req[idx_q];
                rel_to   = LIMITED && (hold_q == CW'(MAX_HOLD));
                if (rel_done || rel_drop || rel_to) begin
                    // The releasing grantee becomes the pointer, so it is searched last.
                    ptr_d     = idx_q;
                    timeout_d = rel_to && !rel_done && !rel_drop;
                    if (resel[IW]) begin
                        idx_d  = resel[IW-1:0];
                        hold_d = CW'(1);
                    end else begin
                        state_d = ST_IDLE;
                        idx_d   = '0;
                        valid_d = 1'b0;
                        hold_d  = '0;
                    end
                end else if (hold_q != '1) begin
                    hold_d = hold_q + CW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = '0;
                valid_d = 1'b0;
                hold_d  = '0;
            end
        endcase

        grant_d = N'(valid_d) << idx_d;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= ST_IDLE;
            ptr_q     <= IW'(N - 1);
            idx_q     <= '0;
            valid_q   <= 1'b0;
            grant_q   <= '0;
            hold_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            idx_q     <= idx_d;
            valid_q   <= valid_d;
            grant_q   <= grant_d;
            hold_q    <= hold_d;
            timeout_q <= timeout_d;
        end
    end

    assign bus.o_grant       = grant_q;
    assign bus.o_grant_idx   = idx_q;
    assign bus.o_grant_valid = valid_q;
    assign bus.o_timeout     = timeout_q;
endmodule

// File: tb/tb_rr_grant_sequencer.sv
// Directed bench for rr_grant_sequencer (N=4, MAX_HOLD=8) with hand-computed expectations.
module tb_rr_grant_sequencer;
    localparam int N  = 4;
    localparam int MH = 8;

    logic i_clk;
    logic i_rst;
    int   n_checks;
    int   n_fail;

    rr_grant_sequencer_if #(.N(N)) bus ();

    rr_grant_sequencer #(.N(N), .MAX_HOLD(MH)) dut (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .bus   (bus.slave)
    );

    // Clock / reset
    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1ns after the edge.
    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic do_reset();
        i_rst      = 1'b1;
        bus.i_req  = '0;
        bus.i_done = 1'b0;
        step();
        i_rst = 1'b0;
    endtask

    task automatic expect_grant(input string tag, input int idx, input logic tmo);
        logic [N-1:0] g;
        g = '0;
        g[idx] = 1'b1;
        chk({tag, "_grant"}, 32'(bus.o_grant), 32'(g));
        chk({tag, "_idx"}, 32'(bus.o_grant_idx), 32'(idx));
        chk({tag, "_valid"}, 32'(bus.o_grant_valid), 32'd1);
        chk({tag, "_tmo"}, 32'(bus.o_timeout), 32'(tmo));
    endtask

    task automatic expect_none(input string tag);
        chk({tag, "_grant"}, 32'(bus.o_grant), 32'd0);
        chk({tag, "_idx"}, 32'(bus.o_grant_idx), 32'd0);
        chk({tag, "_valid"}, 32'(bus.o_grant_valid), 32'd0);
        chk({tag, "_tmo"}, 32'(bus.o_timeout), 32'd0);
    endtask

    int t2_exp[5] = '{0, 1, 2, 3, 0};

    initial begin
        n_checks = 0;
        n_fail   = 0;
        i_rst      = 1'b1;
        bus.i_req  = '0;
        bus.i_done = 1'b0;
        step();
        step();
        i_rst = 1'b0;
        expect_none("reset");

        // T1: ptr=3 after reset, so search 0,1,.. picks 1; other bit changes ignored while held
        bus.i_req = 4'b1010;
        step();
        expect_grant("t1", 1, 1'b0);
        bus.i_req = 4'b1011;
        step();
        expect_grant("t1_hold", 1, 1'b0);

        // T2: back-to-back rotation with done every cycle
        do_reset();
        bus.i_req  = 4'b1111;
        bus.i_done = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            expect_grant($sformatf("t2_%0d", i), t2_exp[i], 1'b0);
        end

        // T3: sole requester held MH cycles, then timeout pulse plus re-grant
        do_reset();
        bus.i_req = 4'b0001;
        for (int c = 1; c <= MH; c++) begin
            step();
            expect_grant($sformatf("t3_c%0d", c), 0, 1'b0);
        end
        step();
        expect_grant("t3_to", 0, 1'b1);
        step();
        expect_grant("t3_after", 0, 1'b0);

        // T4: done coincides with hold limit -> no timeout, next is idx 1
        do_reset();
        bus.i_req = 4'b0011;
        for (int c = 1; c <= MH; c++) step();
        expect_grant("t4_c8", 0, 1'b0);
        bus.i_done = 1'b1;
        step();
        expect_grant("t4_next", 1, 1'b0);
        bus.i_done = 1'b0;

        // T5: grantee 2 drops request; 3 wins, no timeout; then empty -> idle
        do_reset();
        bus.i_req = 4'b0100;
        step();
        expect_grant("t5_g2", 2, 1'b0);
        bus.i_req = 4'b1001;
        step();
        expect_grant("t5_g3", 3, 1'b0);
        step();
        expect_grant("t5_g3b", 3, 1'b0);
        bus.i_req = 4'b0000;
        step();
        expect_none("t5_idle");
        bus.i_done = 1'b1;
        step();
        expect_none("t5_idle_done");
        bus.i_done = 1'b0;

        // T6: reset mid-grant clears everything; first grant afterwards is idx 0
        do_reset();
        bus.i_req = 4'b1000;
        step();
        expect_grant("t6_g3", 3, 1'b0);
        i_rst     = 1'b1;
        bus.i_req = 4'b1111;
        step();
        expect_none("t6_rst");
        i_rst = 1'b0;
        step();
        expect_grant("t6_first", 0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Watchdog
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
